// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the single-cycle RV32I datapath.
// Owns the PC, fetches one instruction at a time over a req/gnt/rvalid port,
// holds it in the instruction register and gates the register-file write so
// each instruction retires exactly once.
//
// Optional feature: define CORE_SEQ_PERF_CNT_EN to add the retired_cnt and
// stall_cnt performance counters.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_req         fetch request, held until granted
//   imem_addr        fetch address (always equals pc)
//   imem_gnt         memory accepted the request
//   imem_rvalid      imem_rdata valid this cycle
//   imem_rdata       fetched instruction word
//   instr            instruction register to decoder / register file / ALU
//   instr_valid      instr is being executed (EXEC and WB)
//   dec_werf         decoder write enable for the current instr
//   dec_illegal      decoder flags the current instr as unsupported
//   stall            external hold of EXEC
//   rf_we            register-file write strobe (combinational, WB only)
//   pc               current program counter
//   halted           sequencer stopped until reset
//   fault_code       00 none, 01 illegal instruction, 10 fetch timeout
//   retired_cnt      (CORE_SEQ_PERF_CNT_EN) WB cycles since reset
//   stall_cnt        (CORE_SEQ_PERF_CNT_EN) stalled EXEC cycles since reset
module core_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        dec_werf,
    input  logic        dec_illegal,
    input  logic        stall,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        halted,
    output logic [1:0]  fault_code
`ifdef CORE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned      CNT_W         = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       FAULT_NONE    = 2'b00;
    localparam logic [1:0]       FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0]       FAULT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt + CNT_W'(1);

    // The address bus simply mirrors the PC; only meaningful while imem_req=1.
    assign imem_addr = pc;

    // Write strobe is confined to the single WB cycle, so a reset that lands
    // mid-instruction can never produce a write.
    assign rf_we = (state == WB) && dec_werf;

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fault_code  <= FAULT_NONE;
            wait_cnt    <= '0;
`ifdef CORE_SEQ_PERF_CNT_EN
            retired_cnt <= '0;
            stall_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end

                // Any rvalid seen here is stale and deliberately ignored.
                FETCH: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        wait_cnt <= '0;
                    end
                end

                // rvalid takes priority over an expiring timeout.
                WAIT: begin
                    if (imem_rvalid) begin
                        state       <= EXEC;
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (wait_cnt_inc == TIMEOUT_LIMIT) begin
                        state      <= HALT;
                        halted     <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                        wait_cnt   <= wait_cnt_inc;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                    end
                end

                // An illegal instruction halts even while stalled.
                EXEC: begin
                    if (dec_illegal) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        fault_code  <= FAULT_ILLEGAL;
                        instr_valid <= 1'b0;
                    end else if (stall) begin
`ifdef CORE_SEQ_PERF_CNT_EN
                        stall_cnt <= stall_cnt + 32'd1;
`endif
                    end else begin
                        state <= WB;
                    end
                end

                WB: begin
                    state       <= FETCH;
                    pc          <= pc + 32'd4;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b1;
`ifdef CORE_SEQ_PERF_CNT_EN
                    retired_cnt <= retired_cnt + 32'd1;
`endif
                end

                // Sticky until reset; every input is ignored.
                HALT: begin
                    state <= HALT;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
